jh_temp_guard: RTL and testbench

//  Thermal safety stage directly downstream of the ADC temperature sampler.

---
 rtl/jh_temp_guard.sv | 155 +++++++++++++++
 tb/tb_jh_temp_guard.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/jh_temp_guard.sv
// Thermal guard: hotter-channel warn/trip evaluation with hysteresis, debounce and sampler watchdog.
// Optional peak-hold register enabled by defining JH_TEMP_PEAK_EN.
module jh_temp_guard #(
    parameter int              TRIP_COUNT     = 3,
    parameter int              WDW            = 24,
    parameter logic [WDW-1:0]  TIMEOUT_CYCLES = 24'd2000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] temperature1,
    input  logic [15:0] temperature2,
    input  logic        en_RF_in,
    input  logic [15:0] warn_limit,
    input  logic [15:0] trip_limit,
    input  logic [15:0] hyst,
    input  logic        fault_clear,
    output logic        en_RF_out,
    output logic        warn,
    output logic        trip,
    output logic        stale,
    output logic [15:0] temp_max,
    output logic        sample_strobe,
    output logic [1:0]  state_out,
    output logic [15:0] peak_temp
);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_WARN   = 2'd1,
        ST_TRIP   = 2'd2,
        ST_STALE  = 2'd3
    } state_t;

    localparam int             CW      = $clog2(TRIP_COUNT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TRIP_COUNT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1'b1);

    state_t          r_state;
    state_t          w_next;
    logic            r_en_d;
    logic            r_en_out;
    logic            r_strobe;
    logic [15:0]     r_temp_max;
    logic [CW-1:0]   r_over_cnt;
    logic [WDW-1:0]  r_wd;

    logic            w_sample;
    logic [15:0]     w_tmax;
    logic [15:0]     w_eval;
    logic [16:0]     w_diff;
    logic [15:0]     w_low;
    logic            w_over;
    logic            w_trip_hit;
    logic            w_timeout;
    logic            w_trip_exit;

    assign w_sample   = en_RF_in & ~r_en_d;
    assign w_tmax     = (temperature1 >= temperature2) ? temperature1 : temperature2;
    assign w_eval     = w_sample ? w_tmax : r_temp_max;
    // Warn-exit threshold clamps at zero when hysteresis exceeds the warn limit.
    assign w_diff     = {1'b0, warn_limit} - {1'b0, hyst};
    assign w_low      = w_diff[16] ? 16'd0 : w_diff[15:0];
    assign w_over     = (w_tmax >= trip_limit);
    assign w_trip_hit = w_over && ((int'(r_over_cnt) + 1) >= TRIP_COUNT);
    assign w_timeout  = (r_wd == WD_LAST);

    always_comb begin
        w_next      = r_state;
        w_trip_exit = 1'b0;
        case (r_state)
            ST_TRIP: begin
                if (fault_clear && (w_eval < w_low)) begin
                    w_next      = ST_NORMAL;
                    w_trip_exit = 1'b1;
                end
            end
            ST_WARN: begin
                if (w_sample) begin
                    if (w_trip_hit)           w_next = ST_TRIP;
                    else if (w_tmax < w_low)  w_next = ST_NORMAL;
                end else if (w_timeout) begin
                    w_next = ST_STALE;
                end
            end
            default: begin
                if (w_sample) begin
                    if (w_trip_hit)                  w_next = ST_TRIP;
                    else if (w_tmax >= warn_limit)   w_next = ST_WARN;
                    else                             w_next = ST_NORMAL;
                end else if (w_timeout) begin
                    w_next = ST_STALE;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_NORMAL;
            r_en_d     <= 1'b0;
            r_en_out   <= 1'b0;
            r_strobe   <= 1'b0;
            r_temp_max <= 16'd0;
            r_over_cnt <= '0;
            r_wd       <= '0;
        end else begin
            r_state  <= w_next;
            r_en_d   <= en_RF_in;
            r_strobe <= w_sample;
            // Gate on the next state so the tripping edge already drops the enable.
            r_en_out <= en_RF_in & ((w_next == ST_NORMAL) || (w_next == ST_WARN));
            if (w_sample) begin
                r_temp_max <= w_tmax;
            end
            if (w_sample) begin
                r_wd <= '0;
            end else if (!w_timeout) begin
                r_wd <= r_wd + 1'b1;
            end
            if (w_trip_exit) begin
                r_over_cnt <= '0;
            end else if (w_sample) begin
                if (!w_over)                     r_over_cnt <= '0;
                else if (r_over_cnt != CNT_MAX)  r_over_cnt <= r_over_cnt + 1'b1;
            end
        end
    end

`ifdef JH_TEMP_PEAK_EN
    logic [15:0] r_peak;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_peak <= 16'd0;
        end else if (w_trip_exit) begin
            r_peak <= r_temp_max;
        end else if (w_sample && (w_tmax > r_peak)) begin
            r_peak <= w_tmax;
        end
    end

    assign peak_temp = r_peak;
`else
    assign peak_temp = 16'd0;
`endif

    assign en_RF_out     = r_en_out;
    assign sample_strobe = r_strobe;
    assign temp_max      = r_temp_max;
    assign state_out     = r_state;
    assign warn          = (r_state == ST_WARN);
    assign trip          = (r_state == ST_TRIP);
    assign stale         = (r_state == ST_STALE);

endmodule

// File: tb/tb_jh_temp_guard.sv
// Directed bench for jh_temp_guard: vector table of sample pairs plus hand-written
// sequences for non-sample TRIP exit, watchdog timeout, reset in TRIP and peak hold.
module tb_jh_temp_guard;

    localparam int T = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] temperature1;
    logic [15:0] temperature2;
    logic        en_RF_in;
    logic [15:0] warn_limit;
    logic [15:0] trip_limit;
    logic [15:0] hyst;
    logic        fault_clear;
    logic        en_RF_out;
    logic        warn;
    logic        trip;
    logic        stale;
    logic [15:0] temp_max;
    logic        sample_strobe;
    logic [1:0]  state_out;
    logic [15:0] peak_temp;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] t1;
        logic [15:0] t2;
        logic        fc;
        logic [1:0]  st;
        logic [15:0] tm;
        logic        en;
    } vec_t;

    vec_t vecs [21];

    jh_temp_guard #(
        .TRIP_COUNT     (3),
        .WDW            (24),
        .TIMEOUT_CYCLES (24'd40)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .temperature1  (temperature1),
        .temperature2  (temperature2),
        .en_RF_in      (en_RF_in),
        .warn_limit    (warn_limit),
        .trip_limit    (trip_limit),
        .hyst          (hyst),
        .fault_clear   (fault_clear),
        .en_RF_out     (en_RF_out),
        .warn          (warn),
        .trip          (trip),
        .stale         (stale),
        .temp_max      (temp_max),
        .sample_strobe (sample_strobe),
        .state_out     (state_out),
        .peak_temp     (peak_temp)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string name, input logic [1:0] exp);
        chk({name, "_state"}, 32'(state_out), 32'(exp));
        chk({name, "_flags"}, {29'd0, warn, trip, stale},
            {29'd0, exp == 2'd1, exp == 2'd2, exp == 2'd3});
    endtask

    // Low cycle, then rising edge of en_RF_in; returns at the negedge after the sample edge.
    task automatic pulse_sample(input logic [15:0] a, input logic [15:0] b, input logic fc);
        @(negedge clock);
        en_RF_in    = 1'b0;
        fault_clear = 1'b0;
        @(negedge clock);
        temperature1 = a;
        temperature2 = b;
        fault_clear  = fc;
        en_RF_in     = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        #200us;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1, "simulation time bound expired");
    end

    initial begin
        // t1, t2, fault_clear, expected state, temp_max, en_RF_out
        vecs[0]  = '{16'd100, 16'd200, 1'b0, 2'd0, 16'd200, 1'b1};
        vecs[1]  = '{16'd310, 16'd0,   1'b0, 2'd1, 16'd310, 1'b1};
        vecs[2]  = '{16'd290, 16'd100, 1'b0, 2'd1, 16'd290, 1'b1};
        vecs[3]  = '{16'd280, 16'd10,  1'b0, 2'd1, 16'd280, 1'b1};
        vecs[4]  = '{16'd279, 16'd279, 1'b0, 2'd0, 16'd279, 1'b1};
        vecs[5]  = '{16'd5,   16'd300, 1'b0, 2'd1, 16'd300, 1'b1};
        vecs[6]  = '{16'd100, 16'd0,   1'b0, 2'd0, 16'd100, 1'b1};
        vecs[7]  = '{16'd410, 16'd0,   1'b0, 2'd1, 16'd410, 1'b1};
        vecs[8]  = '{16'd0,   16'd410, 1'b0, 2'd1, 16'd410, 1'b1};
        vecs[9]  = '{16'd390, 16'd0,   1'b0, 2'd1, 16'd390, 1'b1};
        vecs[10] = '{16'd410, 16'd0,   1'b0, 2'd1, 16'd410, 1'b1};
        vecs[11] = '{16'd410, 16'd0,   1'b0, 2'd1, 16'd410, 1'b1};
        vecs[12] = '{16'd410, 16'd0,   1'b0, 2'd2, 16'd410, 1'b0};
        vecs[13] = '{16'd410, 16'd0,   1'b1, 2'd2, 16'd410, 1'b0};
        vecs[14] = '{16'd200, 16'd0,   1'b1, 2'd0, 16'd200, 1'b1};
        vecs[15] = '{16'd400, 16'd0,   1'b0, 2'd1, 16'd400, 1'b1};
        vecs[16] = '{16'd399, 16'd0,   1'b0, 2'd1, 16'd399, 1'b1};
        vecs[17] = '{16'd400, 16'd0,   1'b0, 2'd1, 16'd400, 1'b1};
        vecs[18] = '{16'd400, 16'd0,   1'b0, 2'd1, 16'd400, 1'b1};
        vecs[19] = '{16'd400, 16'd0,   1'b0, 2'd2, 16'd400, 1'b0};
        vecs[20] = '{16'd100, 16'd0,   1'b0, 2'd2, 16'd100, 1'b0};

        reset        = 1'b1;
        en_RF_in     = 1'b0;
        temperature1 = 16'd0;
        temperature2 = 16'd0;
        warn_limit   = 16'd300;
        trip_limit   = 16'd400;
        hyst         = 16'd20;
        fault_clear  = 1'b0;
        repeat (3) @(negedge clock);
        chk_state("rst", 2'd0);
        chk("rst_en_out", 32'(en_RF_out), 32'd0);
        chk("rst_temp_max", 32'(temp_max), 32'd0);
        chk("rst_strobe", 32'(sample_strobe), 32'd0);
        chk("rst_peak", 32'(peak_temp), 32'd0);
        reset = 1'b0;

        // First sample: enable delayed by one cycle, strobe lasts one cycle.
        @(negedge clock);
        temperature1 = 16'd100;
        temperature2 = 16'd200;
        en_RF_in     = 1'b1;
        #1;
        chk("first_en_out_pre", 32'(en_RF_out), 32'd0);
        @(negedge clock);
        chk("first_strobe", 32'(sample_strobe), 32'd1);
        chk("first_temp_max", 32'(temp_max), 32'd200);
        chk("first_en_out", 32'(en_RF_out), 32'd1);
        chk_state("first", 2'd0);
        @(negedge clock);
        chk("first_strobe_end", 32'(sample_strobe), 32'd0);
        chk("first_en_out_hold", 32'(en_RF_out), 32'd1);

        for (int i = 0; i < 21; i++) begin
            pulse_sample(vecs[i].t1, vecs[i].t2, vecs[i].fc);
            chk_state($sformatf("vec%0d", i), vecs[i].st);
            chk($sformatf("vec%0d_temp_max", i), 32'(temp_max), 32'(vecs[i].tm));
            chk($sformatf("vec%0d_en_out", i), 32'(en_RF_out), 32'(vecs[i].en));
            chk($sformatf("vec%0d_strobe", i), 32'(sample_strobe), 32'd1);
        end

        // TRIP exit on fault_clear alone, judged against the held temp_max of 100.
        @(negedge clock);
        chk_state("trip_hold", 2'd2);
        fault_clear = 1'b1;
        @(negedge clock);
        fault_clear = 1'b0;
        chk_state("trip_clear_nosample", 2'd0);
        chk("trip_clear_en_out", 32'(en_RF_out), 32'd1);

        // Watchdog: STALE exactly T edges after the last sample edge.
        pulse_sample(16'd100, 16'd100, 1'b0);
        chk_state("wd_start", 2'd0);
        repeat (T - 1) @(negedge clock);
        chk_state("wd_before_timeout", 2'd0);
        @(negedge clock);
        chk_state("wd_timeout", 2'd3);
        chk("wd_timeout_en_out", 32'(en_RF_out), 32'd0);
        chk("wd_timeout_en_in", 32'(en_RF_in), 32'd1);
        pulse_sample(16'd100, 16'd50, 1'b0);
        chk_state("stale_recover", 2'd0);
        chk("stale_recover_en_out", 32'(en_RF_out), 32'd1);

        // Sample landing on the timeout edge suppresses STALE.
        repeat (T - 2) @(negedge clock);
        en_RF_in = 1'b0;
        @(negedge clock);
        en_RF_in     = 1'b1;
        temperature1 = 16'd120;
        temperature2 = 16'd0;
        @(negedge clock);
        chk_state("wd_race", 2'd0);
        chk("wd_race_strobe", 32'(sample_strobe), 32'd1);
        chk("wd_race_temp_max", 32'(temp_max), 32'd120);
        repeat (T - 1) @(negedge clock);
        chk_state("wd_restart", 2'd0);
        @(negedge clock);
        chk_state("wd_restart_timeout", 2'd3);
        pulse_sample(16'd350, 16'd0, 1'b0);
        chk_state("stale_to_warn", 2'd1);

        // Reset while in TRIP.
        pulse_sample(16'd500, 16'd0, 1'b0);
        pulse_sample(16'd500, 16'd0, 1'b0);
        chk_state("pre_trip", 2'd1);
        pulse_sample(16'd500, 16'd0, 1'b0);
        chk_state("trip_again", 2'd2);
        reset    = 1'b1;
        en_RF_in = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        chk_state("trip_reset", 2'd0);
        chk("trip_reset_en_out", 32'(en_RF_out), 32'd0);
        chk("trip_reset_temp_max", 32'(temp_max), 32'd0);
        chk("trip_reset_strobe", 32'(sample_strobe), 32'd0);
        chk("trip_reset_peak", 32'(peak_temp), 32'd0);

        // Peak hold.
        pulse_sample(16'd150, 16'd0, 1'b0);
        pulse_sample(16'd0, 16'd350, 1'b0);
        chk_state("peak_mid", 2'd1);
        pulse_sample(16'd200, 16'd0, 1'b0);
        chk_state("peak_end", 2'd0);
        chk("peak_temp_max", 32'(temp_max), 32'd200);
`ifdef JH_TEMP_PEAK_EN
        chk("peak_temp", 32'(peak_temp), 32'd350);
`else
        chk("peak_temp", 32'(peak_temp), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
